// File: rtl/uart_rx.sv
// uart_rx: 8E1 serial receiver. Synchronises rx_in, centre-samples each bit
// cell and reports the byte with parity/framing status as a one-cycle pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | line idle, watching for a falling edge on the synced line
// S_START     | waiting for the centre of the start bit to confirm it
// S_DATA      | sampling the 8 data bits, LSB first
// S_PARITY    | sampling the even-parity bit
// S_STOP      | sampling the stop bit, publishing the result
// S_WAIT_HIGH | stop bit was 0 (break); wait for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam bit HALF_ZERO = (HALF == 0);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? (HALF - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          w_tick;
  logic          w_start_seen;
  logic          w_load_half;
  logic          w_load_bit;
  logic          w_shift;
  logic          w_store_par;
  logic          w_emit;

  assign w_rx_s       = r_sync2;
  assign w_tick       = (r_cnt == '0);
  assign w_start_seen = (r_state == S_IDLE) && !w_rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; every move out of a sampling state happens on a tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx_s) w_state_nxt = HALF_ZERO ? S_DATA : S_START;
      S_START:     if (w_tick) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (w_tick && (r_bitcnt == 3'd7)) w_state_nxt = S_PARITY;
      S_PARITY:    if (w_tick) w_state_nxt = S_STOP;
      S_STOP:      if (w_tick) w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx_s) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode: counter reloads and datapath strobes per state.
  always_comb begin
    w_load_half = 1'b0;
    w_load_bit  = 1'b0;
    w_shift     = 1'b0;
    w_store_par = 1'b0;
    w_emit      = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_load_half = w_start_seen && !HALF_ZERO;
        w_load_bit  = w_start_seen && HALF_ZERO;
      end
      S_START:  w_load_bit = w_tick && !w_rx_s;
      S_DATA: begin
        w_shift    = w_tick;
        w_load_bit = w_tick;
      end
      S_PARITY: begin
        w_store_par = w_tick;
        w_load_bit  = w_tick;
      end
      S_STOP:   w_emit = w_tick;
      default: ;
    endcase
  end

  // Bit-cell down-counter: reloads at each sample instant, parks at zero.
  always_ff @(posedge clk) begin
    if (reset)            r_cnt <= '0;
    else if (w_load_half) r_cnt <= CNT_HALF;
    else if (w_load_bit)  r_cnt <= CNT_BIT;
    else if (!w_tick)     r_cnt <= r_cnt - CW'(1);
  end

  // Shift register, bit counter and captured parity bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_par    <= 1'b0;
    end else begin
      if (r_state != S_DATA) r_bitcnt <= 3'd0;
      else if (w_shift)      r_bitcnt <= r_bitcnt + 3'd1;
      if (w_shift)     r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_store_par) r_par   <= w_rx_s;
    end
  end

  // Result registers: published on the stop sample, held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= w_emit;
      if (w_emit) begin
        rx_data    <= r_shift;
        parity_err <= (^r_shift) ^ r_par;
        frame_err  <= ~w_rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT=1 and 16.
module tb_uart_rx;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx1   = 1'b1;
  logic       rx16  = 1'b1;
  logic [7:0] d1, d16;
  logic       v1, v16, pe1, pe16, fe1, fe16, b1, b16;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q16[$];
  exp_t e1, e16;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .rx_in(rx1), .rx_data(d1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(reset), .rx_in(rx16), .rx_data(d16), .rx_valid(v16),
    .parity_err(pe16), .frame_err(fe16), .busy(b16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rx_valid pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c1_unexpected_valid actual data=%0h expected no frame (cycle %0d)", d1, cyc);
      end else begin
        e1 = q1.pop_front();
        check("c1_data", d1, e1.data);
        check("c1_parity_err", pe1, e1.perr);
        check("c1_frame_err", fe1, e1.ferr);
        check("c1_valid_cycle", cyc, e1.cyc);
      end
    end
    if (v16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c16_unexpected_valid actual data=%0h expected no frame (cycle %0d)", d16, cyc);
      end else begin
        e16 = q16.pop_front();
        check("c16_data", d16, e16.data);
        check("c16_parity_err", pe16, e16.perr);
        check("c16_frame_err", fe16, e16.ferr);
        check("c16_valid_cycle", cyc, e16.cyc);
      end
    end
  end

  // Advance n clocks, leaving time just after the rising edge.
  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit sel16, input logic b);
    if (sel16) rx16 = b;
    else       rx1  = b;
  endtask

  // Drive one 11-bit frame; the reference result comes from the framing rules:
  // parity error when the sent parity bit disagrees with the byte's weight,
  // framing error when the stop bit is 0, pulse at line-edge + 2 + HALF + 10 bits + 1.
  task automatic send_frame(input bit sel16, input logic [7:0] data,
                            input bit bad_par, input bit stop, input bit push);
    int          cpb;
    int          half;
    logic        odd;
    logic        p;
    logic [10:0] bits;
    exp_t        e;
    cpb  = sel16 ? 16 : 1;
    half = (cpb - 1) / 2;
    odd  = (($countones(data) % 2) == 1);
    p    = odd ^ bad_par;
    bits = {stop, p, data, 1'b0};
    e.data = data;
    e.perr = (p != odd);
    e.ferr = !stop;
    e.cyc  = cyc + 3 + half + 10 * cpb;
    if (push) begin
      if (sel16) q16.push_back(e);
      else       q1.push_back(e);
    end
    for (int i = 0; i < 11; i++) begin
      set_line(sel16, bits[i]);
      hold(cpb);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (q1.size() != 0 || q16.size() != 0); i++) hold(1);
    check("pending_frames", q1.size() + q16.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_c1_data"}, d1, 8'h00);
    check({tag, "_c1_valid"}, v1, 1'b0);
    check({tag, "_c1_perr"}, pe1, 1'b0);
    check({tag, "_c1_ferr"}, fe1, 1'b0);
    check({tag, "_c1_busy"}, b1, 1'b0);
    check({tag, "_c16_data"}, d16, 8'h00);
    check({tag, "_c16_valid"}, v16, 1'b0);
    check({tag, "_c16_perr"}, pe16, 1'b0);
    check({tag, "_c16_ferr"}, fe16, 1'b0);
    check({tag, "_c16_busy"}, b16, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          c;
    bit          sel;
    logic [7:0]  dat;
    bit          badp;
    bit          stp;
    int          cpb;
    logic [7:0]  rst_byte;

    hold(3);
    reset = 1'b0;
    check_reset_outputs("reset");
    hold(3);

    // Loopback-style byte at one clock per bit: 13 cycles line-edge to pulse.
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    hold(4);
    drain();

    // Odd-weight byte, correct then wrong parity.
    send_frame(1'b1, 8'h07, 1'b0, 1'b1, 1'b1);
    hold(20);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    hold(20);
    drain();

    // Framing error followed by a held-low break.
    send_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("break_busy_high", b16, 1'b1);
      @(posedge clk);
      #1;
    end
    set_line(1'b1, 1'b1);
    hold(5);
    @(negedge clk);
    check("break_busy_released", b16, 1'b0);
    @(posedge clk);
    #1;
    drain();
    hold(20);

    // False start: 4-cycle low pulse.
    c = cyc;
    rx16 = 1'b0;
    hold(4);
    rx16 = 1'b1;
    while (cyc < c + 5) hold(1);
    @(negedge clk);
    check("false_start_busy_rise", b16, 1'b1);
    @(posedge clk);
    #1;
    while (cyc < c + 10) hold(1);
    @(negedge clk);
    check("false_start_busy_fall", b16, 1'b0);
    @(posedge clk);
    #1;
    hold(40);

    // Back-to-back frames with no idle bit between them.
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    hold(4);
    drain();
    hold(5);

    // Reset during data bit 4 of a 0x55 frame, then a clean 0x81.
    rst_byte = 8'h55;
    rx16 = 1'b0;
    hold(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = rst_byte[i];
      hold(16);
    end
    rx16 = rst_byte[4];
    hold(8);
    reset = 1'b1;
    hold(1);
    reset = 1'b0;
    rx16  = 1'b1;
    check_reset_outputs("mid_frame_reset");
    hold(200);
    send_frame(1'b1, 8'h81, 1'b0, 1'b1, 1'b1);
    hold(20);
    drain();

    // Randomised traffic on both receivers, with breaks, bad parity and glitches.
    for (int n = 0; n < 40; n++) begin
      sel = ($urandom_range(0, 1) == 1);
      cpb = sel ? 16 : 1;
      if (sel && $urandom_range(0, 9) == 0) begin
        rx16 = 1'b0;
        hold($urandom_range(1, 6));
        rx16 = 1'b1;
        hold(20);
      end else begin
        dat  = 8'($urandom);
        badp = ($urandom_range(0, 4) == 0);
        stp  = ($urandom_range(0, 5) != 0);
        send_frame(sel, dat, badp, stp, 1'b1);
        if (!stp) begin
          hold($urandom_range(0, 30));
          set_line(sel, 1'b1);
          hold(cpb + 3);
        end else begin
          hold($urandom_range(0, 2) * cpb);
        end
      end
    end
    hold(10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the single-wire UART line driven by the team's transmitter: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1). It synchronises the line into `clk`, locates each frame, samples every bit at its centre, and presents the byte with parity and framing status as a one-cycle valid pulse. It sits directly downstream of the transmitter, either on-chip in loopback or across the board-level serial link.

## Interface
- `CLKS_PER_BIT`, default 1: `clk` cycles per serial bit. Legal values are ≥1. The value 1 matches a transmitter that emits one bit per clock.
- `clk`  input  1  system clock; all logic is rising-edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx_in`  input  1  serial line. Asynchronous to `clk`. Idles high.
- `rx_data`  output  8  last received byte.
- `rx_valid`  output  1  one-cycle pulse when a frame completes.
- `parity_err`  output  1  received parity bit ≠ XOR of `rx_data`. Valid with `rx_valid`.
- `frame_err`  output  1  stop bit sampled as 0. Valid with `rx_valid`.
- `busy`  output  1  high while a frame is in progress (any state except IDLE).

## Operation
- **Synchroniser:** 2-flop chain on `rx_in`, producing `rx_s`. Both flops reset to 1. All decisions below use `rx_s`.
- **Derived constant:** HALF = (CLKS_PER_BIT−1)/2, using integer division.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **Sample instants:** let t0 be the first cycle in IDLE with `rx_s`=0.
  - Start bit is checked at t0+HALF.
  - Data bit i (i=0..7) is sampled at t0+HALF+(i+1)·CLKS_PER_BIT.
  - Parity bit is sampled at t0+HALF+9·CLKS_PER_BIT.
  - Stop bit is sampled at t0+HALF+10·CLKS_PER_BIT.
- **IDLE:** on `rx_s`=0, go to START. When HALF=0 the start check happens in the detection cycle itself, so IDLE goes directly to DATA.
- **START:** at the start check:
  - `rx_s`=1 → false start; return to IDLE with no output.
  - `rx_s`=0 → go to DATA.
- **DATA:** shift sampled bits into the shift register LSB first, using a 3-bit bit counter. After bit 7 is sampled, go to PARITY.
- **PARITY:** store the sampled bit, then go to STOP.
- **STOP:** on the stop sample edge, all of the following happen together:
  - `rx_data` ← shift register.
  - `parity_err` ← (^shift) ^ parity_bit.
  - `frame_err` ← ~`rx_s`.
  - `rx_valid` ← 1 for one cycle.
- **Exit from STOP:**
  - Stop bit = 1 → go to IDLE. A new start can be detected on the very next cycle.
  - Stop bit = 0 → go to WAIT_HIGH.
- **WAIT_HIGH:** remain until `rx_s`=1, then go to IDLE. This prevents a break condition from being decoded as repeated frames.
- **Output hold:** `rx_data`, `parity_err` and `frame_err` hold until the next `rx_valid`.
- **Errored frames:** frames with an error still pulse `rx_valid`. Consumers decide whether to discard.
- **Bit-cell counter:** width is $clog2(CLKS_PER_BIT)+1. It reloads at every sample instant and never wraps past CLKS_PER_BIT−1.

## Timing
- **Reset values:**
  - `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - State = IDLE; synchroniser flops = 1.
- **Reset mid-frame:** the frame is abandoned and no `rx_valid` is produced. After reset deasserts, reception restarts from IDLE and needs a fresh falling edge.
- **Latency:**
  - `rx_in` change → `rx_s`: 2 cycles.
  - `rx_s` start edge (t0) → `rx_valid`: HALF+10·CLKS_PER_BIT+1 cycles. For CLKS_PER_BIT=1 this is 11 cycles.
  - `rx_in` falling edge → `rx_valid`: 13 cycles at CLKS_PER_BIT=1.
- **Throughput:** back-to-back frames are accepted when the next start bit immediately follows the stop bit, with zero idle bits between frames.
- **Busy:** `busy` rises the cycle after t0 (or at the DATA entry when HALF=0). It falls in the cycle `rx_valid` is high when the stop bit is 1, or on leaving WAIT_HIGH.
- **Glitch rejection:** a 0-glitch shorter than HALF cycles is rejected as a false start. This only applies when CLKS_PER_BIT≥3.

## Test plan
- **Loopback, CLKS_PER_BIT=1:** transmitter sends switches=0xA5 → exactly one `rx_valid`, 13 cycles after the TX start bit appears on the line; `rx_data`=0xA5, `parity_err`=0, `frame_err`=0.
- **Odd-weight byte, CLKS_PER_BIT=16:** send 0x07 with parity=1 (correct) → `parity_err`=0. Repeat with parity forced to 0 → `rx_valid` pulses, `rx_data`=0x07, `parity_err`=1.
- **Framing error, CLKS_PER_BIT=16:** send 0x3C with stop=0, then hold the line low for 40 cycles, then release high → exactly one `rx_valid` with `frame_err`=1, `rx_data`=0x3C. No further frames are decoded while the line is low; `busy` stays 1 until `rx_s` returns high.
- **False start, CLKS_PER_BIT=16:** 4-cycle low pulse on an idle line → no `rx_valid`; `busy` returns to 0 by cycle t0+8.
- **Back-to-back, CLKS_PER_BIT=1:** frames 0x00 then 0xFF with no idle bit between them → two `rx_valid` pulses 11 cycles apart; data 0x00 then 0xFF; no errors.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of a 0x55 frame → all outputs at reset values, no `rx_valid`. A following 0x81 frame is received correctly.
